lc3b_pmem_arbiter: RTL and testbench
====================================

// Module: lc3b_pmem_arbiter
// PURPOSE
//  Shares the single physical-memory port between the I-cache (line fills) and the D-cache (fills + writebacks).
//  Sits between both caches and pmem; one line transaction (lc3b_line, 128 b) is outstanding at a time.
//  Round-robin tie-break; transaction parameters latched at grant; pmem rdata returned through a registered response.
// PARAMETERS
//  ADDR_W    16   byte address width (lc3b_word)
//  LINE_W    128  line width (lc3b_line)
//  OFFSET_W  4    line-offset bits forced to 0 on pmem_address (lc3b_c_offset)
//  CNT_W     16   width of saturating conflict counter
// PORTS
//  clk              in   1       clock, all state on rising edge
//  rst_n            in   1       asynchronous, active-low reset
//  i_pmem_read      in   1       I-cache line read request, level, held until i_pmem_resp
//  i_pmem_address   in   ADDR_W  I-cache request address
//  i_pmem_rdata     out  LINE_W  line returned to I-cache, valid with i_pmem_resp
//  i_pmem_resp      out  1       one-cycle completion pulse to I-cache
//  d_pmem_read      in   1       D-cache line read request, level
//  d_pmem_write     in   1       D-cache line write (writeback) request, level
//  d_pmem_address   in   ADDR_W  D-cache request address
//  d_pmem_wdata     in   LINE_W  writeback line
//  d_pmem_rdata     out  LINE_W  line returned to D-cache, valid with d_pmem_resp
//  d_pmem_resp      out  1       one-cycle completion pulse to D-cache
//  pmem_read        out  1       read strobe to pmem, held until pmem_resp
//  pmem_write       out  1       write strobe to pmem, held until pmem_resp
//  pmem_address     out  ADDR_W  line-aligned address {addr[ADDR_W-1:OFFSET_W], OFFSET_W'b0}
//  pmem_wdata       out  LINE_W  latched writeback data
//  pmem_rdata       in   LINE_W  pmem read data, valid with pmem_resp
//  pmem_resp        in   1       pmem completion, one cycle
//  arb_busy         out  1       high in any state other than IDLE
//  conflict_count   out  CNT_W   # IDLE cycles with both requesters pending, saturates at all-ones
// BEHAVIOUR
//  Reset (rst_n=0, immediate): state=IDLE, every output 0 (rdata regs 0), last_grant=D, conflict_count=0.
//   Reset mid-transaction abandons it; no resp is issued; pmem strobes drop asynchronously.
//  States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
//  IDLE: req_i=i_pmem_read, req_d=d_pmem_read|d_pmem_write.
//   only req_i -> BUSY_I; only req_d -> BUSY_D; both -> grant side != last_grant, conflict_count++.
//   On grant: latch address, wdata, op (d write wins if d_pmem_read & d_pmem_write both high), set last_grant.
//  BUSY_x: pmem_read/pmem_write driven from latched op (registered, first asserted cycle after grant).
//   Requester inputs ignored while busy; changes do not affect the active transaction.
//   pmem_resp=1 -> capture pmem_rdata into x_pmem_rdata (reads only; write leaves it unchanged), go RESP_x.
//  RESP_x: x_pmem_resp=1 for exactly this cycle; pmem strobes 0; next state IDLE unconditionally.
//  Latency: request in IDLE cycle t -> pmem strobe at t+1 -> pmem_resp at t+k -> x_resp at t+k+1;
//   earliest re-grant at t+k+2. Requester must deassert the edge after seeing its resp.
//  pmem_resp outside BUSY_x is ignored. pmem strobes never both high; never high in IDLE/RESP.
//  Fairness: with both continuously requesting, grants strictly alternate I,D,I,D (first tie after reset -> I).
//  x_pmem_rdata holds its value between transactions.
// STRUCTURE
//  lc3b_types additions: lc3b_arb_state enum (5 states); reuse lc3b_word, lc3b_line, lc3b_c_offset.
//  Sub-module lc3b_rr_arbiter2: 2-input round-robin pick + last_grant flop, enabled only in IDLE.
//  Remainder (FSM, latch regs, rdata regs, counter) in this module.
// TESTING
//  1 Reset: rst_n low mid BUSY_D with pmem_write=1 -> all outputs 0 same cycle; no d_pmem_resp after release.
//  2 I only: i_read addr 16'h123A, pmem_resp 3 cycles later with rdata=128'hA5..A5 -> pmem_address 16'h1230,
//    i_pmem_resp 1 cycle, i_pmem_rdata=A5..A5, d_pmem_resp stays 0.
//  3 D write: d_write addr 16'h4008 wdata=128'h0123..CDEF -> pmem_write=1, pmem_address 16'h4000,
//    pmem_wdata matches, d_pmem_resp pulse, d_pmem_rdata unchanged.
//  4 Tie: both request from reset, hold 4 transactions -> grant order I,D,I,D; conflict_count=4.
//  5 Input change while busy: D granted, then d_pmem_address changes 16'h4000->16'h8000 -> pmem_address stays 16'h4000.
//  6 Stray/overlap: pmem_resp pulsed in IDLE -> no resp out; d_read&d_write both high -> pmem_write only.

Source files
------------

// File: rtl/lc3b_pmem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lc3b_pmem_arbiter_pkg : shared types for the pmem arbiter                  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package lc3b_pmem_arbiter_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;
    typedef logic [3:0]   lc3b_c_offset;

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_BUSY_I = 3'd1,
        ARB_BUSY_D = 3'd2,
        ARB_RESP_I = 3'd3,
        ARB_RESP_D = 3'd4
    } lc3b_arb_state;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } lc3b_grant_e;

endpackage
`default_nettype wire

// File: rtl/lc3b_pmem_arbiter_rr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lc3b_rr_arbiter2 : two-input round-robin pick with last-grant memory       |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module lc3b_rr_arbiter2
    import lc3b_pmem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_i,
    input  logic req_d,
    output logic grant_i,
    output logic grant_d
);

    lc3b_grant_e last_grant_q;
    lc3b_grant_e last_grant_d;

    // On a tie the side that did not win last time goes first.
    always_comb begin
        grant_i      = en && req_i && (!req_d || (last_grant_q == GRANT_D));
        grant_d      = en && req_d && !grant_i;
        last_grant_d = last_grant_q;
        if (grant_i) begin
            last_grant_d = GRANT_I;
        end else if (grant_d) begin
            last_grant_d = GRANT_D;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GRANT_D;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lc3b_pmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lc3b_pmem_arbiter : shares the pmem line port between I-cache and D-cache  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module lc3b_pmem_arbiter
    import lc3b_pmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = $bits(lc3b_word),
    parameter int LINE_W   = $bits(lc3b_line),
    parameter int OFFSET_W = $bits(lc3b_c_offset),
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              arb_busy,
    output logic [CNT_W-1:0]  conflict_count
);

    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    lc3b_arb_state     state_q,          state_d;
    logic              pmem_read_q,      pmem_read_d;
    logic              pmem_write_q,     pmem_write_d;
    logic [ADDR_W-1:0] pmem_address_q,   pmem_address_d;
    logic [LINE_W-1:0] pmem_wdata_q,     pmem_wdata_d;
    logic [LINE_W-1:0] i_rdata_q,        i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q,        d_rdata_d;
    logic              i_resp_q,         i_resp_d;
    logic              d_resp_q,         d_resp_d;
    logic [CNT_W-1:0]  conflict_count_q, conflict_count_d;

    logic req_i;
    logic req_d;
    logic grant_i;
    logic grant_d;
    logic in_idle;

    assign req_i   = i_pmem_read;
    assign req_d   = d_pmem_read | d_pmem_write;
    assign in_idle = (state_q == ARB_IDLE);

    lc3b_rr_arbiter2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (in_idle),
        .req_i   (req_i),
        .req_d   (req_d),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    always_comb begin
        state_d          = state_q;
        pmem_read_d      = pmem_read_q;
        pmem_write_d     = pmem_write_q;
        pmem_address_d   = pmem_address_q;
        pmem_wdata_d     = pmem_wdata_q;
        i_rdata_d        = i_rdata_q;
        d_rdata_d        = d_rdata_q;
        i_resp_d         = 1'b0;
        d_resp_d         = 1'b0;
        conflict_count_d = conflict_count_q;

        case (state_q)
            ARB_IDLE: begin
                if (req_i && req_d && !(&conflict_count_q)) begin
                    conflict_count_d = conflict_count_q + CNT_W'(1);
                end
                if (grant_i) begin
                    state_d        = ARB_BUSY_I;
                    pmem_read_d    = 1'b1;
                    pmem_write_d   = 1'b0;
                    pmem_address_d = i_pmem_address & LINE_MASK;
                end else if (grant_d) begin
                    // A writeback takes precedence when both D strobes are raised.
                    state_d        = ARB_BUSY_D;
                    pmem_read_d    = !d_pmem_write;
                    pmem_write_d   = d_pmem_write;
                    pmem_address_d = d_pmem_address & LINE_MASK;
                    pmem_wdata_d   = d_pmem_wdata;
                end
            end
            ARB_BUSY_I: begin
                if (pmem_resp) begin
                    state_d      = ARB_RESP_I;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    i_rdata_d    = pmem_rdata;
                    i_resp_d     = 1'b1;
                end
            end
            ARB_BUSY_D: begin
                if (pmem_resp) begin
                    state_d      = ARB_RESP_D;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    d_resp_d     = 1'b1;
                    if (pmem_read_q) begin
                        d_rdata_d = pmem_rdata;
                    end
                end
            end
            ARB_RESP_I, ARB_RESP_D: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d      = ARB_IDLE;
                pmem_read_d  = 1'b0;
                pmem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ARB_IDLE;
            pmem_read_q      <= 1'b0;
            pmem_write_q     <= 1'b0;
            pmem_address_q   <= '0;
            pmem_wdata_q     <= '0;
            i_rdata_q        <= '0;
            d_rdata_q        <= '0;
            i_resp_q         <= 1'b0;
            d_resp_q         <= 1'b0;
            conflict_count_q <= '0;
        end else begin
            state_q          <= state_d;
            pmem_read_q      <= pmem_read_d;
            pmem_write_q     <= pmem_write_d;
            pmem_address_q   <= pmem_address_d;
            pmem_wdata_q     <= pmem_wdata_d;
            i_rdata_q        <= i_rdata_d;
            d_rdata_q        <= d_rdata_d;
            i_resp_q         <= i_resp_d;
            d_resp_q         <= d_resp_d;
            conflict_count_q <= conflict_count_d;
        end
    end

    assign pmem_read      = pmem_read_q;
    assign pmem_write     = pmem_write_q;
    assign pmem_address   = pmem_address_q;
    assign pmem_wdata     = pmem_wdata_q;
    assign i_pmem_rdata   = i_rdata_q;
    assign d_pmem_rdata   = d_rdata_q;
    assign i_pmem_resp    = i_resp_q;
    assign d_pmem_resp    = d_resp_q;
    assign arb_busy       = !in_idle;
    assign conflict_count = conflict_count_q;

endmodule
`default_nettype wire

// File: tb/tb_lc3b_pmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lc3b_pmem_arbiter : directed + random bench with transaction model      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_lc3b_pmem_arbiter;

    logic         clk;
    logic         rst_n;
    logic         i_pmem_read;
    logic [15:0]  i_pmem_address;
    logic [127:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [15:0]  d_pmem_address;
    logic [127:0] d_pmem_wdata;
    logic [127:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic         arb_busy;
    logic [15:0]  conflict_count;

    int n_checks = 0;
    int n_fail   = 0;

    lc3b_pmem_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp),
        .arb_busy       (arb_busy),
        .conflict_count (conflict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_w(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_l(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: at most one line transfer in flight,
    // described by who owns it, its op, and whether its reply is showing.
    logic         e_read, e_write, e_iresp, e_dresp, e_busy;
    logic [15:0]  e_addr, e_cnt;
    logic [127:0] e_wdata, e_irdata, e_drdata;
    logic         m_is_d, m_in_resp, m_last_d;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_read = 0; e_write = 0; e_iresp = 0; e_dresp = 0; e_busy = 0;
            e_addr = '0; e_cnt = '0; e_wdata = '0; e_irdata = '0; e_drdata = '0;
            m_is_d = 0; m_in_resp = 0; m_last_d = 1;
        end else if (m_in_resp) begin
            e_iresp = 0; e_dresp = 0; e_busy = 0; m_in_resp = 0;
        end else if (!e_busy) begin
            logic ri, rd, take_i, take_d;
            ri = i_pmem_read;
            rd = d_pmem_read | d_pmem_write;
            if (ri && rd && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
            take_i = ri && (!rd || m_last_d);
            take_d = rd && !take_i;
            if (take_i) begin
                e_busy = 1; m_is_d = 0; m_last_d = 0;
                e_addr = i_pmem_address & 16'hFFF0;
                e_read = 1; e_write = 0;
            end else if (take_d) begin
                e_busy = 1; m_is_d = 1; m_last_d = 1;
                e_addr = d_pmem_address & 16'hFFF0;
                e_write = d_pmem_write; e_read = !d_pmem_write;
                e_wdata = d_pmem_wdata;
            end
        end else if (pmem_resp) begin
            if (!m_is_d) e_irdata = pmem_rdata;
            else if (e_read) e_drdata = pmem_rdata;
            if (m_is_d) e_dresp = 1; else e_iresp = 1;
            e_read = 0; e_write = 0; m_in_resp = 1;
        end
    end

    always @(negedge clk) begin
        chk_b("m_pmem_read",   pmem_read,      e_read);
        chk_b("m_pmem_write",  pmem_write,     e_write);
        chk_w("m_pmem_addr",   pmem_address,   e_addr);
        if (e_write) chk_l("m_pmem_wdata", pmem_wdata, e_wdata);
        chk_b("m_i_resp",      i_pmem_resp,    e_iresp);
        chk_b("m_d_resp",      d_pmem_resp,    e_dresp);
        chk_l("m_i_rdata",     i_pmem_rdata,   e_irdata);
        chk_l("m_d_rdata",     d_pmem_rdata,   e_drdata);
        chk_b("m_busy",        arb_busy,       e_busy);
        chk_w("m_conflicts",   conflict_count, e_cnt);
        chk_b("m_strobe_excl", pmem_read & pmem_write, 1'b0);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_strobe(input string name);
        bit seen;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (pmem_read || pmem_write) seen = 1;
            else step();
        end
        chk_b(name, seen, 1'b1);
    endtask

    initial begin
        rst_n = 0;
        i_pmem_read = 0; i_pmem_address = '0;
        d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
        pmem_rdata = '0; pmem_resp = 0;
        step(); step();
        chk_b("reset_busy", arb_busy, 1'b0);
        chk_w("reset_cnt", conflict_count, 16'h0000);
        rst_n = 1;
        step();

        // I-cache read, pmem answers three cycles after the strobe
        i_pmem_read = 1; i_pmem_address = 16'h123A;
        step();
        chk_b("t2_read", pmem_read, 1'b1);
        chk_w("t2_addr", pmem_address, 16'h1230);
        step(); step();
        pmem_resp = 1; pmem_rdata = {16{8'hA5}};
        step();
        pmem_resp = 0; pmem_rdata = '0; i_pmem_read = 0;
        chk_b("t2_iresp", i_pmem_resp, 1'b1);
        chk_l("t2_irdata", i_pmem_rdata, {16{8'hA5}});
        chk_b("t2_dresp", d_pmem_resp, 1'b0);
        step();
        chk_b("t2_iresp_off", i_pmem_resp, 1'b0);
        chk_l("t2_irdata_hold", i_pmem_rdata, {16{8'hA5}});

        // D-cache writeback
        d_pmem_write = 1; d_pmem_address = 16'h4008;
        d_pmem_wdata = 128'h0123456789ABCDEF0123456789ABCDEF;
        step();
        chk_b("t3_write", pmem_write, 1'b1);
        chk_b("t3_read", pmem_read, 1'b0);
        chk_w("t3_addr", pmem_address, 16'h4000);
        chk_l("t3_wdata", pmem_wdata, 128'h0123456789ABCDEF0123456789ABCDEF);
        step();
        pmem_resp = 1; pmem_rdata = {16{8'h5A}};
        step();
        pmem_resp = 0; d_pmem_write = 0;
        chk_b("t3_dresp", d_pmem_resp, 1'b1);
        chk_l("t3_drdata", d_pmem_rdata, 128'h0);
        step();

        // stray pmem_resp in IDLE, then read+write together
        pmem_resp = 1;
        step(); step();
        chk_b("t6_iresp", i_pmem_resp, 1'b0);
        chk_b("t6_dresp", d_pmem_resp, 1'b0);
        chk_b("t6_busy", arb_busy, 1'b0);
        pmem_resp = 0;
        d_pmem_read = 1; d_pmem_write = 1; d_pmem_address = 16'h2222;
        step();
        chk_b("t6_write", pmem_write, 1'b1);
        chk_b("t6_read", pmem_read, 1'b0);
        pmem_resp = 1;
        step();
        pmem_resp = 0; d_pmem_read = 0; d_pmem_write = 0;
        chk_l("t6_drdata", d_pmem_rdata, 128'h0);
        step();

        // requester inputs change while busy
        d_pmem_read = 1; d_pmem_address = 16'h4000;
        step();
        chk_w("t5_addr0", pmem_address, 16'h4000);
        d_pmem_address = 16'h8000; d_pmem_read = 0;
        step();
        chk_w("t5_addr1", pmem_address, 16'h4000);
        chk_b("t5_read", pmem_read, 1'b1);
        pmem_resp = 1; pmem_rdata = 128'hDEADBEEF_00000000_CAFEF00D_12345678;
        step();
        pmem_resp = 0;
        chk_b("t5_dresp", d_pmem_resp, 1'b1);
        chk_l("t5_drdata", d_pmem_rdata, 128'hDEADBEEF_00000000_CAFEF00D_12345678);
        step();

        // reset in the middle of a D writeback
        d_pmem_write = 1; d_pmem_address = 16'h4008;
        step();
        chk_b("t1_write_pre", pmem_write, 1'b1);
        step();
        #2 rst_n = 0;
        #1;
        chk_b("t1_write", pmem_write, 1'b0);
        chk_b("t1_busy", arb_busy, 1'b0);
        chk_w("t1_addr", pmem_address, 16'h0000);
        chk_l("t1_irdata", i_pmem_rdata, 128'h0);
        chk_l("t1_drdata", d_pmem_rdata, 128'h0);
        d_pmem_write = 0;
        step();
        rst_n = 1; pmem_resp = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_b("t1_no_dresp", d_pmem_resp, 1'b0);
        end
        pmem_resp = 0;

        // continuous tie from reset: grants alternate I,D,I,D
        rst_n = 0;
        i_pmem_read = 1; i_pmem_address = 16'h1114;
        d_pmem_read = 1; d_pmem_address = 16'h2228;
        step();
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            wait_strobe("t4_strobe_timeout");
            chk_w($sformatf("t4_grant%0d", k), pmem_address, (k % 2 == 0) ? 16'h1110 : 16'h2220);
            step();
            pmem_resp = 1; pmem_rdata = {4{32'(k)}};
            step();
            pmem_resp = 0;
            if (k == 3) begin
                i_pmem_read = 0; d_pmem_read = 0;
            end
            step();
        end
        step();
        chk_w("t4_conflicts", conflict_count, 16'd4);

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            i_pmem_read    = ($urandom_range(0, 99) < 45);
            i_pmem_address = 16'($urandom);
            d_pmem_read    = ($urandom_range(0, 99) < 35);
            d_pmem_write   = ($urandom_range(0, 99) < 25);
            d_pmem_address = 16'($urandom);
            d_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
            pmem_resp      = ($urandom_range(0, 3) == 0);
            pmem_rdata     = {$urandom, $urandom, $urandom, $urandom};
            if (n % 700 == 350) begin
                #2 rst_n = 0;
                #1 rst_n = 1;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
